// File: rtl/ucsbece154a_memory_responder_if.sv
// Request/response bus between the multicycle core's memory wrapper (master)
// and the unified instruction/data memory responder (slave).
interface ucsbece154a_memory_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wd_i;
    logic [31:0] rd_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wd_i,
        input  rd_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wd_i,
        output rd_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/ucsbece154a_memory_responder.sv
// Word-addressed unified memory: one access at a time, WAIT_CYCLES wait states,
// one-cycle ready/err completion pulse, misaligned/out-of-range detection.
module ucsbece154a_memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    ucsbece154a_memory_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : (WAIT_CYCLES - 1));

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic                    r_we;
    logic [31:0]             r_wd;
    logic                    r_err;
    logic [31:0]             r_rd;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_sample;
    logic                    w_req_err;
    logic                    w_enter_done;
    logic [ADDR_WIDTH-1:0]   w_acc_idx;
    logic                    w_acc_we;
    logic [31:0]             w_acc_wd;
    logic                    w_acc_err;

    assign w_sample  = (r_state == S_IDLE) && bus.req_i;
    assign w_req_err = (bus.addr_i[1:0] != 2'b00) ||
                       (bus.addr_i[31:ADDR_WIDTH+2] != '0);

    // With zero wait states DONE is entered on the sampling edge itself, so the
    // access must come straight from the bus instead of the latched copy.
    assign w_acc_idx = (r_state == S_IDLE) ? bus.addr_i[ADDR_WIDTH+1:2] : r_idx;
    assign w_acc_we  = (r_state == S_IDLE) ? bus.we_i  : r_we;
    assign w_acc_wd  = (r_state == S_IDLE) ? bus.wd_i  : r_wd;
    assign w_acc_err = (r_state == S_IDLE) ? w_req_err : r_err;

    // Next-state and wait-counter decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = WAIT_INIT;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, request latch and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wd    <= 32'h0;
            r_err   <= 1'b0;
            r_rd    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_sample) begin
                r_idx <= bus.addr_i[ADDR_WIDTH+1:2];
                r_we  <= bus.we_i;
                r_wd  <= bus.wd_i;
                r_err <= w_req_err;
            end
            if (w_enter_done) begin
                if (w_acc_err) begin
                    r_rd <= 32'h0;
                end else if (!w_acc_we) begin
                    r_rd <= r_mem[w_acc_idx];
                end
            end
        end
    end

    // Array write; contents survive reset, but reset still blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_done && w_acc_we && !w_acc_err) begin
            r_mem[w_acc_idx] <= w_acc_wd;
        end
    end

    assign bus.rd_o    = r_rd;
    assign bus.ready_o = (r_state == S_DONE);
    assign bus.err_o   = (r_state == S_DONE) && r_err;
    assign bus.busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_ucsbece154a_memory_responder.sv
// Scoreboard bench: four responders (W = 2, 0, 4, 1) driven one at a time;
// a negedge monitor checks every ready pulse against queued expectations.
module tb_ucsbece154a_memory_responder;

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [3:0]  req_v;
    logic [3:0]  we_v;
    logic [3:0]  rst_v;
    logic [31:0] addr_v [4];
    logic [31:0] wd_v   [4];
    logic [3:0]  rdy;
    logic [3:0]  errv;
    logic [3:0]  busyv;
    logic [31:0] rdv    [4];
    logic [31:0] mdl_rd [4];

    typedef struct {
        int          dut;
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    function automatic int wait_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 4 : 1;
        ucsbece154a_memory_responder_if bus ();
        assign bus.req_i  = req_v[g];
        assign bus.we_i   = we_v[g];
        assign bus.addr_i = addr_v[g];
        assign bus.wd_i   = wd_v[g];
        assign rdy[g]     = bus.ready_o;
        assign errv[g]    = bus.err_o;
        assign busyv[g]   = bus.busy_o;
        assign rdv[g]     = bus.rd_o;
        ucsbece154a_memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .bus   (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rdy[d]) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d cycle %0d rd=%h err=%0b, no access pending",
                             d, cyc, rdv[d], errv[d]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.dut != d || e.cyc != cyc || e.err != errv[d] || e.rd != rdv[d]) begin
                        n_fail++;
                        $display("FAIL response dut%0d cycle %0d rd=%h err=%0b, required dut%0d cycle %0d rd=%h err=%0b",
                                 d, cyc, rdv[d], errv[d], e.dut, e.cyc, e.rd, e.err);
                    end
                end
            end
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_ready dut%0d: no pulse by cycle %0d (required at cycle %0d)",
                     sb[0].dut, cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access; the caller is at a negedge with the target in IDLE.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd_exp, input logic hold);
        exp_t e;
        int   w;
        w     = wait_of(d);
        e.dut = d;
        e.cyc = cyc + 1 + w;
        e.err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        if (e.err)   e.rd = 32'h0;
        else if (we) e.rd = mdl_rd[d];
        else         e.rd = rd_exp;
        mdl_rd[d] = e.rd;
        sb.push_back(e);
        req_v[d]  = 1'b1;
        we_v[d]   = we;
        addr_v[d] = addr;
        wd_v[d]   = wd;
        repeat (w + 2) @(negedge clk);
        if (!hold) req_v[d] = 1'b0;
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        req_v    = 4'b1111;
        we_v     = 4'b0000;
        rst_v    = 4'b1111;
        for (int d = 0; d < 4; d++) begin
            addr_v[d] = 32'h0;
            wd_v[d]   = 32'h0;
            mdl_rd[d] = 32'h0;
        end

        // Reset held two edges with req high on every instance.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_rd%0d", d),    rdv[d],          32'h0);
            chk($sformatf("reset_ready%0d", d), {31'd0, rdy[d]}, 32'h0);
            chk($sformatf("reset_err%0d", d),   {31'd0, errv[d]}, 32'h0);
            chk($sformatf("reset_busy%0d", d),  {31'd0, busyv[d]}, 32'h0);
        end
        rst_v = 4'b0000;
        req_v = 4'b0000;
        @(negedge clk);
        chk("post_reset_busy", {28'd0, busyv}, 32'h0);

        // W=2: write/read, misaligned write, out-of-range read, rd hold on write.
        access(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        access(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access(0, 1'b1, 32'h13,  32'h11111111, 32'h0,        1'b0);
        access(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b0);
        access(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access(0, 1'b1, 32'h14,  32'hA5A5A5A5, 32'h0,        1'b0);
        access(0, 1'b0, 32'h14,  32'h0,        32'hA5A5A5A5, 1'b0);

        // W=0: preload, then held-request reads every 2 cycles, then a misaligned read.
        access(1, 1'b1, 32'h8, 32'h0BADF00D, 32'h0,        1'b0);
        access(1, 1'b1, 32'hC, 32'h600DCAFE, 32'h0,        1'b0);
        access(1, 1'b0, 32'h8, 32'h0,        32'h0BADF00D, 1'b1);
        access(1, 1'b0, 32'hC, 32'h0,        32'h600DCAFE, 1'b1);
        access(1, 1'b0, 32'h8, 32'h0,        32'h0BADF00D, 1'b0);
        access(1, 1'b0, 32'h2, 32'h0,        32'h0,        1'b0);

        // W=4: reset lands at E2 of a write, which must never commit.
        access(2, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        req_v[2]  = 1'b1;
        we_v[2]   = 1'b1;
        addr_v[2] = 32'h20;
        wd_v[2]   = 32'h12345678;
        @(negedge clk);
        req_v[2] = 1'b0;
        chk("midwait_busy_before", {31'd0, busyv[2]}, 32'h1);
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        chk("midwait_busy_after", {31'd0, busyv[2]}, 32'h0);
        chk("midwait_rd_after",   rdv[2],            32'h0);
        mdl_rd[2] = 32'h0;
        repeat (8) @(negedge clk);
        access(2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // W=1: preload then back-to-back reads with req held high.
        access(3, 1'b1, 32'h0, 32'h10101010, 32'h0, 1'b0);
        access(3, 1'b1, 32'h4, 32'h20202020, 32'h0, 1'b0);
        access(3, 1'b1, 32'h8, 32'h30303030, 32'h0, 1'b0);
        access(3, 1'b0, 32'h0, 32'h0, 32'h10101010, 1'b1);
        access(3, 1'b0, 32'h4, 32'h0, 32'h20202020, 1'b1);
        access(3, 1'b0, 32'h8, 32'h0, 32'h30303030, 1'b0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
